nbit_universal_shift_register: RTL and testbench
================================================

// Module: nbit_universal_shift_register
// PURPOSE
//   Parametrised universal shift register, successor to the N-bit bidirectional shifter.
//   Supports single-step hold/shift/rotate/arithmetic-shift/load/clear.
//   Adds a counted burst mode: one start command performs N shifts or rotates autonomously, with busy/done status.
//   Used as a serialiser/deserialiser and barrel-shift helper in datapath blocks.
// PARAMETERS
//   WIDTH      16   register width in bits (>=2)
//   CNT_W      5    width of burst count input; max burst = 2**CNT_W-1
//   RESET_VAL  0    value loaded into outdata on reset/CLEAR (WIDTH bits)
// PORTS
//   clk              in   1       rising-edge clock
//   reset            in   1       synchronous, active-high reset
//   enable           in   1       1 = register may update this edge; 0 = hold (stalls burst)
//   mode             in   3       operation select (see BEHAVIOUR)
//   start            in   1       begin counted burst of operation 'mode' (shift/rotate modes only)
//   count            in   CNT_W   number of operations in burst, sampled with start
//   load_data        in   WIDTH   parallel load value for LOAD
//   serial_in_left   in   1       bit entering MSB on SHR
//   serial_in_right  in   1       bit entering LSB on SHL
//   outdata          out  WIDTH   register contents
//   serial_out_msb   out  1       outdata[WIDTH-1] (combinational)
//   serial_out_lsb   out  1       outdata[0] (combinational)
//   busy             out  1       burst in progress, further operations pending
//   done             out  1       one-cycle pulse after final operation of a burst
// BEHAVIOUR
//   - Reset (sync, priority over everything): outdata=RESET_VAL, FSM=IDLE, remaining=0, busy=0, done=0.
//   - Modes (one op per enabled edge, result visible next cycle; "left" = toward MSB):
//     000 HOLD; 001 SHL {q[W-2:0],serial_in_right}; 010 SHR {serial_in_left,q[W-1:1]};
//     011 ROL {q[W-2:0],q[W-1]}; 100 ROR {q[0],q[W-1:1]}; 101 ASR {q[W-1],q[W-1:1]};
//     110 LOAD q=load_data; 111 CLEAR q=RESET_VAL.
//   - FSM states IDLE, BURST. done defaults to 0 on every edge unless set below.
//   - IDLE, enable=1, start=0: execute mode once.
//   - IDLE, enable=1, start=1, mode in 001..101:
//     - latch mode into burst_mode;
//     - count=0: no op, done=1 next cycle, stay IDLE.
//     - count=1: one op on this edge, done=1 next cycle, stay IDLE, busy stays 0.
//     - count>=2: one op on this edge, remaining=count-1, busy=1, go BURST.
//   - IDLE, start=1 with mode HOLD/LOAD/CLEAR: start ignored; mode executed as single step.
//   - IDLE, enable=0: nothing changes; start ignored (not queued).
//   - BURST, enable=1: execute burst_mode, remaining-=1.
//     - If remaining was 1: go IDLE, busy=0, done=1 next cycle.
//     - mode/start/count/load_data ignored while in BURST.
//   - BURST, enable=0: full stall, remaining, outdata and busy held.
//   - Serial inputs sampled at each shifting edge (not latched at start).
//   - count>WIDTH legal: shifts fill with serial input; rotates wrap modulo WIDTH.
//   - Burst of N (enable held high) = N consecutive edges starting at the start edge.
//     - busy high N-1 cycles; done high exactly one cycle, immediately after the Nth op.
//   - Reset mid-burst aborts: no done pulse; outdata=RESET_VAL next cycle.
// TESTING
//   1 reset=1 one edge with junk inputs -> outdata=0, busy=0, done=0; hold 0 over 3 HOLD cycles.
//   2 LOAD 0xA5C3, then SHL with serial_in_right=1 -> 0x4B87.
//     - serial_out_msb=1 before the shift, 0 after.
//   3 LOAD 0x1234; start ROR count=4 -> 0x4123 after 4 edges.
//     - busy=1 for 3 cycles; done=1 for exactly 1 cycle; mode changes during burst have no effect.
//   4 LOAD 0x8000; start ASR count=3 with enable dropped 2 cycles mid-burst.
//     - Value held during stall; final 0xF000; done once, 2 cycles later than unstalled.
//   5 Start SHR count=10, reset asserted after 4th op -> outdata=0, busy=0, no done pulse.
//     - Next start works normally.
//   6 start with count=0 -> outdata unchanged, done pulse next cycle.
//     - start with mode=LOAD -> plain load, no done pulse.

Source files
------------

// File: rtl/nbit_universal_shift_register.sv
// nbit_universal_shift_register: single-step shift/rotate/load/clear register with counted burst mode
module nbit_universal_shift_register #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  output logic [WIDTH-1:0] outdata,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [2:0] burst_mode, burst_mode_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic [WIDTH-1:0] q_n;
  logic done_n;
  logic burstable;
  function automatic logic [WIDTH-1:0] step(input logic [2:0] m, input logic [WIDTH-1:0] q);
    case (m)
      3'd1:    step = {q[WIDTH-2:0], serial_in_right};
      3'd2:    step = {serial_in_left, q[WIDTH-1:1]};
      3'd3:    step = {q[WIDTH-2:0], q[WIDTH-1]};
      3'd4:    step = {q[0], q[WIDTH-1:1]};
      3'd5:    step = {q[WIDTH-1], q[WIDTH-1:1]};
      3'd6:    step = load_data;
      3'd7:    step = RESET_VAL;
      default: step = q;
    endcase
  endfunction
  assign burstable = start && (mode inside {[3'd1:3'd5]});
  always_comb begin
    state_n = state;
    burst_mode_n = burst_mode;
    remaining_n = remaining;
    q_n = outdata;
    done_n = 1'b0;
    if (enable) begin
      if (state == BURST) begin
        q_n = step(burst_mode, outdata);
        remaining_n = remaining - 1'b1;
        state_n = (remaining == CNT_W'(1)) ? IDLE : BURST;
        done_n = (remaining == CNT_W'(1));
      end else if (burstable) begin
        burst_mode_n = mode;
        q_n = (count == '0) ? outdata : step(mode, outdata);
        done_n = (count <= CNT_W'(1));
        remaining_n = (count <= CNT_W'(1)) ? '0 : count - 1'b1;
        state_n = (count <= CNT_W'(1)) ? IDLE : BURST;
      end else begin
        q_n = step(mode, outdata);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      burst_mode <= 3'd0;
      remaining <= '0;
      outdata <= RESET_VAL;
      done <= 1'b0;
    end else begin
      state <= state_n;
      burst_mode <= burst_mode_n;
      remaining <= remaining_n;
      outdata <= q_n;
      done <= done_n;
    end
  end
  assign busy = (state == BURST);
  assign serial_out_msb = outdata[WIDTH-1];
  assign serial_out_lsb = outdata[0];
endmodule

// File: tb/tb_nbit_universal_shift_register.sv
// tb_nbit_universal_shift_register: vector table, directed burst sequences and randomized model check
module tb_nbit_universal_shift_register;
  localparam int W = 16;
  localparam int M = 1 << W;
  logic clk = 0, reset, enable, start, serial_in_left, serial_in_right;
  logic [2:0] mode;
  logic [4:0] count;
  logic [W-1:0] load_data, outdata;
  logic serial_out_msb, serial_out_lsb, busy, done;
  int total = 0, passed = 0;
  int m_q = 0, m_rem = 0, m_bm = 0;
  bit m_done = 0;

  nbit_universal_shift_register #(.WIDTH(W), .CNT_W(5), .RESET_VAL('0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start), .count(count),
    .load_data(load_data), .serial_in_left(serial_in_left), .serial_in_right(serial_in_right),
    .outdata(outdata), .serial_out_msb(serial_out_msb), .serial_out_lsb(serial_out_lsb),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en; logic [2:0] md; logic st; logic [4:0] cnt; logic [15:0] ld; logic sl, sr;
    logic [15:0] q; logic b, d;
  } vec_t;
  vec_t vecs[20];

  function automatic int apply(int m, int v, int sl, int sr, int ld);
    case (m)
      1: return (v * 2) % M + sr;
      2: return v / 2 + sl * (M / 2);
      3: return (v * 2) % M + v / (M / 2);
      4: return v / 2 + (v % 2) * (M / 2);
      5: return v / 2 + (v / (M / 2)) * (M / 2);
      6: return ld;
      7: return 0;
      default: return v;
    endcase
  endfunction

  task automatic model_step();
    bit d = 0;
    if (reset) begin
      m_q = 0; m_rem = 0; m_done = 0;
    end else begin
      if (enable) begin
        if (m_rem > 0) begin
          m_q = apply(m_bm, m_q, serial_in_left, serial_in_right, load_data);
          m_rem--;
          d = (m_rem == 0);
        end else if (start && mode >= 1 && mode <= 5) begin
          m_bm = mode;
          if (count > 0) m_q = apply(mode, m_q, serial_in_left, serial_in_right, load_data);
          if (count <= 1) d = 1; else m_rem = count - 1;
        end else m_q = apply(mode, m_q, serial_in_left, serial_in_right, load_data);
      end
      m_done = d;
    end
  endtask

  task automatic cyc(input logic r, e, input logic [2:0] m, input logic s, input logic [4:0] c,
                     input logic [15:0] l, input logic a, b);
    reset = r; enable = e; mode = m; start = s; count = c; load_data = l;
    serial_in_left = a; serial_in_right = b;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic expect_st(input string n, input logic [15:0] q, input logic b, d);
    chk({n, "_q"}, outdata, q);
    chk({n, "_busy"}, busy, b);
    chk({n, "_done"}, done, d);
    chk({n, "_msb"}, serial_out_msb, q[15]);
    chk({n, "_lsb"}, serial_out_lsb, q[0]);
  endtask

  initial begin
    reset = 1; enable = 0; mode = 0; start = 0; count = 0; load_data = 0;
    serial_in_left = 0; serial_in_right = 0;
    vecs = '{
      '{1, 1, 6, 1, 7, 16'hFFFF, 1, 1, 16'h0000, 0, 0},
      '{0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0},
      '{0, 1, 0, 0, 0, 16'hFFFF, 1, 1, 16'h0000, 0, 0},
      '{0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0},
      '{0, 1, 6, 0, 0, 16'hA5C3, 0, 0, 16'hA5C3, 0, 0},
      '{0, 1, 1, 0, 0, 16'h0000, 0, 1, 16'h4B87, 0, 0},
      '{0, 1, 2, 0, 0, 16'h0000, 1, 0, 16'hA5C3, 0, 0},
      '{0, 1, 3, 0, 0, 16'h0000, 0, 0, 16'h4B87, 0, 0},
      '{0, 1, 4, 0, 0, 16'h0000, 0, 0, 16'hA5C3, 0, 0},
      '{0, 1, 5, 0, 0, 16'h0000, 0, 0, 16'hD2E1, 0, 0},
      '{0, 0, 7, 0, 0, 16'h0000, 0, 0, 16'hD2E1, 0, 0},
      '{0, 0, 1, 1, 3, 16'h0000, 0, 1, 16'hD2E1, 0, 0},
      '{0, 1, 7, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0},
      '{0, 1, 6, 0, 0, 16'h1234, 0, 0, 16'h1234, 0, 0},
      '{0, 1, 1, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1},
      '{0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h1234, 0, 0},
      '{0, 1, 6, 1, 5, 16'hBEEF, 0, 0, 16'hBEEF, 0, 0},
      '{0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 0},
      '{0, 1, 3, 1, 1, 16'h0000, 0, 0, 16'h7DDF, 0, 1},
      '{0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h7DDF, 0, 0}
    };
    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].rst, vecs[i].en, vecs[i].md, vecs[i].st, vecs[i].cnt, vecs[i].ld, vecs[i].sl, vecs[i].sr);
      expect_st($sformatf("vec%0d", i), vecs[i].q, vecs[i].b, vecs[i].d);
    end

    cyc(0, 1, 6, 0, 0, 16'h1234, 0, 0); expect_st("ror_load", 16'h1234, 0, 0);
    cyc(0, 1, 4, 1, 4, 16'h0000, 0, 0); expect_st("ror_e1", 16'h091A, 1, 0);
    cyc(0, 1, 6, 1, 9, 16'hFFFF, 1, 1); expect_st("ror_e2", 16'h048D, 1, 0);
    cyc(0, 1, 7, 0, 0, 16'hFFFF, 1, 1); expect_st("ror_e3", 16'h8246, 1, 0);
    cyc(0, 1, 1, 1, 2, 16'hFFFF, 1, 1); expect_st("ror_e4", 16'h4123, 0, 1);
    cyc(0, 1, 0, 0, 0, 16'h0000, 0, 0); expect_st("ror_after", 16'h4123, 0, 0);

    cyc(0, 1, 6, 0, 0, 16'h8000, 0, 0); expect_st("asr_load", 16'h8000, 0, 0);
    cyc(0, 1, 5, 1, 3, 16'h0000, 0, 0); expect_st("asr_e1", 16'hC000, 1, 0);
    cyc(0, 0, 7, 1, 0, 16'h0000, 0, 0); expect_st("asr_stall1", 16'hC000, 1, 0);
    cyc(0, 0, 6, 0, 0, 16'h0000, 0, 0); expect_st("asr_stall2", 16'hC000, 1, 0);
    cyc(0, 1, 0, 0, 0, 16'h0000, 0, 0); expect_st("asr_e2", 16'hE000, 1, 0);
    cyc(0, 1, 0, 0, 0, 16'h0000, 0, 0); expect_st("asr_e3", 16'hF000, 0, 1);
    cyc(0, 1, 0, 0, 0, 16'h0000, 0, 0); expect_st("asr_after", 16'hF000, 0, 0);

    cyc(0, 1, 6, 0, 0, 16'h00FF, 0, 0); expect_st("shr_load", 16'h00FF, 0, 0);
    cyc(0, 1, 2, 1, 10, 16'h0000, 1, 0); expect_st("shr_e1", 16'h807F, 1, 0);
    cyc(0, 1, 0, 0, 0, 16'h0000, 1, 0); expect_st("shr_e2", 16'hC03F, 1, 0);
    cyc(0, 1, 0, 0, 0, 16'h0000, 1, 0); expect_st("shr_e3", 16'hE01F, 1, 0);
    cyc(0, 1, 0, 0, 0, 16'h0000, 1, 0); expect_st("shr_e4", 16'hF00F, 1, 0);
    cyc(1, 1, 0, 0, 0, 16'h0000, 1, 0); expect_st("shr_reset", 16'h0000, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 0, 16'h0000, 1, 0); expect_st("shr_nodone", 16'h0000, 0, 0);
    end
    cyc(0, 1, 1, 1, 2, 16'h0000, 0, 1); expect_st("restart_e1", 16'h0001, 1, 0);
    cyc(0, 1, 0, 0, 0, 16'h0000, 0, 1); expect_st("restart_e2", 16'h0003, 0, 1);
    cyc(0, 1, 0, 0, 0, 16'h0000, 0, 0); expect_st("restart_after", 16'h0003, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 80) == 0, $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
          $urandom_range(0, 5) == 0, 5'($urandom_range(0, 31)), 16'($urandom),
          1'($urandom), 1'($urandom));
      chk("rand_q", outdata, m_q[15:0]);
      chk("rand_busy", busy, m_rem > 0);
      chk("rand_done", done, m_done);
      chk("rand_msb", serial_out_msb, m_q[15]);
      chk("rand_lsb", serial_out_lsb, m_q[0]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
